// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants and destination encodings for the 1-to-2 word demultiplexer
package demux_pkg;

    localparam int DEMUX_WIDTH = 16;
    localparam int DEMUX_CNT_W = 8;

    localparam logic DEST_CH0 = 1'b0;
    localparam logic DEST_CH1 = 1'b1;

endpackage

// File: rtl/demux_out_slot.sv
// rtl/demux_out_slot.sv - one-entry output holding register with valid flag and delivery counter
module demux_out_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH,
    parameter int CNT_W = DEMUX_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] cnt
);

    logic deliver;

    // A delivery happens whenever the slot is occupied and its consumer accepts.
    assign deliver = valid && ready;

    // Holding register: a load wins over a delivery so the slot stays full at full rate;
    // data is left untouched when the slot empties.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (deliver) begin
            valid <= 1'b0;
        end
    end

    // Delivered-word counter, wrapping naturally at its width.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (deliver) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/demux_16_1to2_reg.sv
// rtl/demux_16_1to2_reg.sv - registered 1-to-2 demux top; DEMUX_16_ALTERNATE_EN selects strict alternation
module demux_16_1to2_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH,
    parameter int CNT_W = DEMUX_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic dest;
    logic accept;
    logic load0;
    logic load1;

`ifdef DEMUX_16_ALTERNATE_EN
    logic toggle;

    // Alternation state: flips after every accepted word so destinations go 0,1,0,1...
    always_ff @(posedge clk) begin
        if (reset) begin
            toggle <= DEST_CH0;
        end else if (accept) begin
            toggle <= ~toggle;
        end
    end

    // in_sel is intentionally ignored in this build.
    assign dest = toggle;
`else
    assign dest = in_sel;
`endif

    // Ready depends only on the destination slot, never on in_valid, to avoid a comb loop upstream.
    always_comb begin
        in_ready = 1'b0;
        if (dest == DEST_CH0) begin
            in_ready = !out0_valid || out0_ready;
        end else begin
            in_ready = !out1_valid || out1_ready;
        end
    end

    assign accept = in_valid && in_ready;
    assign load0  = accept && (dest == DEST_CH0);
    assign load1  = accept && (dest == DEST_CH1);

    demux_out_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot0 (
        .clk       (clk),
        .reset     (reset),
        .load      (load0),
        .load_data (in_data),
        .ready     (out0_ready),
        .valid     (out0_valid),
        .data      (out0_data),
        .cnt       (cnt0)
    );

    demux_out_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot1 (
        .clk       (clk),
        .reset     (reset),
        .load      (load1),
        .load_data (in_data),
        .ready     (out1_ready),
        .valid     (out1_valid),
        .data      (out1_data),
        .cnt       (cnt1)
    );

endmodule

// File: tb/tb_demux_16_1to2_reg.sv
// tb/tb_demux_16_1to2_reg.sv - randomized self-checking bench with a per-channel occupancy model
module tb_demux_16_1to2_reg;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_sel = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] out0_data;
    logic        out0_valid;
    logic        out0_ready = 1'b0;
    logic [15:0] out1_data;
    logic        out1_valid;
    logic        out1_ready = 1'b0;
    logic [7:0]  cnt0;
    logic [7:0]  cnt1;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: each channel is a mailbox holding at most one word.
    int          m_full [2];
    logic [15:0] m_data [2];
    int          m_cnt  [2];
    int          m_tog;

    demux_16_1to2_reg dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_dest(input logic s);
`ifdef DEMUX_16_ALTERNATE_EN
        return m_tog;
`else
        return int'(s);
`endif
    endfunction

    function automatic logic model_ready(input logic s, input logic r0, input logic r1);
        int d;
        logic r;
        d = model_dest(s);
        r = (d == 0) ? r0 : r1;
        return (m_full[d] == 0) || r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_full[i] = 0;
            m_data[i] = '0;
            m_cnt[i]  = 0;
        end
        m_tog = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".out0_valid"}, 32'(out0_valid), 32'(m_full[0] != 0));
        check({tag, ".out0_data"},  32'(out0_data),  32'(m_data[0]));
        check({tag, ".out1_valid"}, 32'(out1_valid), 32'(m_full[1] != 0));
        check({tag, ".out1_data"},  32'(out1_data),  32'(m_data[1]));
        check({tag, ".cnt0"},       32'(cnt0),       32'(m_cnt[0]));
        check({tag, ".cnt1"},       32'(cnt1),       32'(m_cnt[1]));
    endtask

    // Called 1 time unit after a rising edge; returns with the same phase one cycle later.
    task automatic step(input string tag, input logic v, input logic s, input logic [15:0] d,
                        input logic r0, input logic r1, output logic acc);
        logic exp_rdy;
        int   dst;
        in_valid   = v;
        in_sel     = s;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
        #4;
        exp_rdy = model_ready(s, r0, r1);
        check({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
        acc = v && exp_rdy;
        dst = model_dest(s);
        if (m_full[0] != 0 && r0) begin
            m_full[0] = 0;
            m_cnt[0]  = (m_cnt[0] + 1) % 256;
        end
        if (m_full[1] != 0 && r1) begin
            m_full[1] = 0;
            m_cnt[1]  = (m_cnt[1] + 1) % 256;
        end
        if (acc) begin
            m_full[dst] = 1;
            m_data[dst] = d;
            m_tog       = 1 - m_tog;
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset(input int cycles);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'($urandom);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            check("rst.out0_valid", 32'(out0_valid), 32'd0);
            check("rst.out1_valid", 32'(out1_valid), 32'd0);
            check("rst.out0_data",  32'(out0_data),  32'd0);
            check("rst.out1_data",  32'(out1_data),  32'd0);
            check("rst.cnt0",       32'(cnt0),       32'd0);
            check("rst.cnt1",       32'(cnt1),       32'd0);
        end
        model_reset();
        reset    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        logic        acc;
        logic        pv;
        logic        ps;
        logic [15:0] pd;
        logic        hold;

        model_reset();
        @(posedge clk);
        #1;
        do_reset(2);

        // in_ready after reset for both selections, with consumers stalled
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        in_sel = 1'b0;
        #1;
        check("post_rst.in_ready.sel0", 32'(in_ready), 32'd1);
        in_sel = 1'b1;
        #1;
        check("post_rst.in_ready.sel1", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Route to channel 0 with its consumer stalled
        step("route0", 1'b1, 1'b0, 16'hA5A5, 1'b0, 1'b0, acc);
        check("route0.out0_data_const", 32'(out0_data), 32'h0000A5A5);
        check("route0.out0_valid_const", 32'(out0_valid), 32'd1);
`ifndef DEMUX_16_ALTERNATE_EN
        in_valid = 1'b0;
        in_sel = 1'b0;
        #1;
        check("route0.in_ready.sel0", 32'(in_ready), 32'd0);
        in_sel = 1'b1;
        #1;
        check("route0.in_ready.sel1", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
`endif

        // Independent stall: ch0 still full and stalled, word to ch1 goes through
        step("stall", 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, acc);
`ifndef DEMUX_16_ALTERNATE_EN
        check("stall.out1_data_const", 32'(out1_data), 32'h00001234);
        check("stall.out0_data_held", 32'(out0_data), 32'h0000A5A5);
`endif

        // Back-to-back full rate on channel 1
        do_reset(1);
        for (int i = 1; i <= 4; i++) begin
            step("b2b", 1'b1, 1'b1, 16'(i), 1'b1, 1'b1, acc);
        end
        step("b2b_drain", 1'b0, 1'b1, 16'h0, 1'b1, 1'b1, acc);
`ifndef DEMUX_16_ALTERNATE_EN
        check("b2b.cnt1_const", 32'(cnt1), 32'd4);
`endif

        // Counter wrap: 256 deliveries on channel 0
        do_reset(1);
        for (int i = 0; i < 256; i++) begin
            step("wrap", 1'b1, 1'b0, 16'(i), 1'b1, 1'b1, acc);
        end
        step("wrap_drain", 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, acc);
`ifndef DEMUX_16_ALTERNATE_EN
        check("wrap.cnt0_const", 32'(cnt0), 32'd0);
        check("wrap.cnt1_const", 32'(cnt1), 32'd0);
`endif

`ifdef DEMUX_16_ALTERNATE_EN
        // Strict alternation with in_sel held at 1
        do_reset(1);
        step("alt0", 1'b1, 1'b1, 16'h0010, 1'b1, 1'b1, acc);
        check("alt0.out0_data_const", 32'(out0_data), 32'h00000010);
        step("alt1", 1'b1, 1'b1, 16'h0011, 1'b1, 1'b1, acc);
        check("alt1.out1_data_const", 32'(out1_data), 32'h00000011);
        step("alt2", 1'b1, 1'b1, 16'h0012, 1'b1, 1'b1, acc);
        check("alt2.out0_data_const", 32'(out0_data), 32'h00000012);
`endif

        // Random traffic, holding a refused word stable until it is accepted
        do_reset(1);
        hold = 1'b0;
        pv = 1'b0;
        ps = 1'b0;
        pd = '0;
        for (int i = 0; i < 600; i++) begin
            if (!hold) begin
                pv = ($urandom_range(0, 3) != 0);
                ps = 1'($urandom);
                pd = 16'($urandom);
            end
            step("rand", pv, ps, pd, ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0), acc);
            hold = pv && !acc;
            if (i == 300) begin
                do_reset(1);
                hold = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/demux_16_1to2_reg.md
Name: demux_16_1to2_reg

Overview:
- Registered 1-to-2 demultiplexer for 16-bit words.
- Routes each accepted input word to one of two output channels selected by in_sel.
- Each channel has a one-entry holding register and a valid/ready handshake.
- Sits downstream of a single producer and feeds two independent consumers (e.g. register-file write port vs. memory write path).

Parameters:
- WIDTH, 16, data word width in bits.
- CNT_W, 8, width of each per-channel delivered-word counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  input word.
- in_sel  input  1  destination: 0 = channel 0, 1 = channel 1.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block can accept the word this cycle.
- out0_data  output  WIDTH  channel 0 held word.
- out0_valid  output  1  channel 0 slot occupied.
- out0_ready  input  1  channel 0 consumer accepts.
- out1_data  output  WIDTH  channel 1 held word.
- out1_valid  output  1  channel 1 slot occupied.
- out1_ready  input  1  channel 1 consumer accepts.
- cnt0  output  CNT_W  words delivered on channel 0.
- cnt1  output  CNT_W  words delivered on channel 1.

Behaviour:
- Reset (clk edge with reset=1) clears out0_data, out1_data, out0_valid, out1_valid, cnt0 and cnt1 to 0. Reset overrides all other activity; a word held mid-handshake is dropped.
- Destination d is in_sel, or the toggle state when the optional feature is enabled.
- in_ready = !outd_valid || outd_ready. This is combinational from the destination, outd_valid and outd_ready; there is no path from in_valid.
- Accept: in_valid && in_ready at a clk edge.
  - On accept, outd_data <= in_data and outd_valid <= 1.
  - Latency is 1 cycle: the word is visible on outd the cycle after accept.
- Delivery on channel X: outX_valid && outX_ready at a clk edge.
  - Delivery without a same-cycle accept to X: outX_valid <= 0.
  - outX_data retains its last value when the slot is empty.
- Simultaneous delivery and accept on the same channel: outX_valid stays 1 and data is replaced by the new word. This gives full throughput of 1 word/cycle per channel.
- Channels are independent. The non-selected channel drains regardless of in_sel, and a stall on one channel never blocks delivery on the other.
- While in_valid=1 and in_ready=0, the producer holds in_data and in_sel stable. Behaviour is unspecified if the producer violates this.
- cntX increments by 1 on each delivery on channel X and wraps modulo 2^CNT_W (255 -> 0 at default).
- With in_valid=0, no slot is loaded; deliveries still proceed.

Optional Feature:
- Macro DEMUX_16_ALTERNATE_EN.
- Defined:
  - An internal toggle bit (reset to 0) replaces in_sel as the destination.
  - The toggle inverts after every accept, giving strict alternation 0,1,0,1...
  - in_sel stays on the port list but is ignored.
  - in_ready follows the toggle's channel.
- Not defined: the destination is in_sel and no toggle state exists.

Decomposition:
- Shared package demux_pkg holds:
  - constants DEMUX_WIDTH=16 and DEMUX_CNT_W=8;
  - destination encodings DEST_CH0=1'b0 and DEST_CH1=1'b1.
- One sub-module, demux_out_slot, is natural:
  - it contains one holding register, the valid flag and the delivery counter;
  - it has load/data inputs, a ready input and valid/data/count outputs;
  - it is instantiated twice.
- The top level contains only destination decode, in_ready generation and the optional toggle.

Test Plan:
- Reset: hold reset 2 cycles with in_valid=1 -> all outputs 0, no load; after release, in_ready=1 for both selections.
- Route to channel 0: in_data=16'hA5A5, in_sel=0, in_valid=1, out0_ready=0 for one cycle. Next cycle out0_valid=1 and out0_data=16'hA5A5, out1_valid=0, and in_ready=0 for sel=0 but 1 for sel=1.
- Back-to-back full-rate: out1_ready=1, send 16'h0001..16'h0004 with sel=1 on consecutive cycles -> in_ready stays 1, out1_data follows one cycle behind, cnt1 reaches 4.
- Independent stall: out0 full with out0_ready=0, send 16'h1234 with sel=1 -> accepted and out1 shows 16'h1234; out0 holds its word unchanged.
- Counter wrap: deliver 256 words on channel 0 -> cnt0 returns to 0; cnt1 unchanged.
- With DEMUX_16_ALTERNATE_EN: both ready=1, in_sel held at 1, send 16'h0010, 16'h0011, 16'h0012 -> delivered to ch0, ch1, ch0 respectively.
